// File: rtl/tt_um_diego_uart_tx.sv
// -----------------------------------------------------------------------------
// tt_um_diego_uart_tx
//
// Tiny Tapeout user tile: serial UART transmitter (8N1, LSB first).
// A byte presented on ui_in is accepted when uio_in[0] (valid) is high while
// the transmitter is ready. It is then shifted out on uo_out[0] as:
//   start bit (0), data bits 0..7, [even parity], stop bit (1).
// Every bit lasts DIV clock cycles. All outputs are registered.
//
// Optional feature macro: TT_UART_PARITY_EN
//   When defined, an even-parity bit (XOR of the 8 data bits) is sent between
//   the last data bit and the stop bit. When undefined, no parity logic exists.
//
// Parameters:
//   DIV      clock cycles per UART bit period (>= 2)
//
// Ports:
//   clk      tile clock, rising-edge active
//   rst_n    synchronous active-low reset
//   ena      tile enable (always 1 when powered; ignored)
//   ui_in    byte to transmit, sampled only at acceptance
//   uio_in   bit0 = valid (send request); bits 7:1 ignored
//   uo_out   bit0 = tx (idle high), bit1 = ready, bit2 = busy, bits 7:3 = 0
//   uio_out  constant 0
//   uio_oe   constant 0 (all IO pins are inputs)
// -----------------------------------------------------------------------------
module tt_um_diego_uart_tx #(
    parameter int DIV = 87
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam int CNT_W = $clog2(DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef TT_UART_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4
    } tx_state_e;

    tx_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [2:0]       idx_q,   idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             tx_q,    tx_d;
    logic             ready_q, ready_d;

    logic valid;
    logic wrap;

    assign valid = uio_in[0];
    assign wrap  = (cnt_q == CNT_LAST);

    // Deliberately unconnected tile inputs, gathered so they are visibly consumed.
    logic unused_inputs;
    assign unused_inputs = &{1'b0, ena, uio_in[7:1], 1'b0};

    // -------------------------------------------------------------------------
    // Next-state / next-output logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // it unassigned; otherwise synthesis would infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        ready_d = ready_q;

        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                idx_d = '0;
                if (ready_q && valid) begin
                    shift_d = ui_in;
                    tx_d    = 1'b0;          // start bit
                    ready_d = 1'b0;
                    state_d = START;
                end
            end

            START: begin
                if (wrap) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    tx_d    = shift_q[0];
                    state_d = DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            DATA: begin
                if (wrap) begin
                    cnt_d = '0;
                    if (idx_q == 3'd7) begin
                        idx_d   = '0;
`ifdef TT_UART_PARITY_EN
                        tx_d    = ^shift_q;  // even parity over latched byte
                        state_d = PARITY;
`else
                        tx_d    = 1'b1;      // stop bit
                        state_d = STOP;
`endif
                    end else begin
                        // The shift register holds the latched byte unchanged;
                        // the bit index selects the next bit to drive.
                        idx_d = idx_q + 3'd1;
                        tx_d  = shift_q[idx_q + 3'd1];
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

`ifdef TT_UART_PARITY_EN
            PARITY: begin
                if (wrap) begin
                    cnt_d   = '0;
                    tx_d    = 1'b1;          // stop bit
                    state_d = STOP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`endif

            STOP: begin
                if (wrap) begin
                    cnt_d   = '0;
                    tx_d    = 1'b1;
                    ready_d = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                idx_d   = '0;
                tx_d    = 1'b1;
                ready_d = 1'b1;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State register (synchronous active-low reset)
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            ready_q <= ready_d;
        end
    end

    // busy is derived from the ready register only, so it is glitch-free and
    // has no path from the inputs.
    assign uo_out  = {5'b0, ~ready_q, ready_q, tx_q};
    assign uio_out = 8'h00;
    assign uio_oe  = 8'h00;

endmodule

// File: tb/tb_tt_um_diego_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_tt_um_diego_uart_tx
//
// Self-checking bench for tt_um_diego_uart_tx with DIV = 4. A frame-level
// reference model (cycles since acceptance -> bit position in the frame)
// predicts uo_out after every clock edge. Directed scenarios are followed by a
// randomized phase with random bytes, valid requests and occasional resets.
// -----------------------------------------------------------------------------
module tb_tt_um_diego_uart_tx;

    localparam int DIV = 4;
`ifdef TT_UART_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic [7:0] ui_in = 8'h00;
    logic [7:0] uio_in = 8'h00;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    tt_um_diego_uart_tx #(.DIV(DIV)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (time %0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit         m_busy = 1'b0;
    int         m_t    = 0;      // edges elapsed since acceptance
    logic [7:0] m_byte = 8'h00;

    // Level on the line at position k (0 = start) of a frame carrying b.
    function automatic logic frame_bit(input int k, input logic [7:0] b);
        if (k == 0) return 1'b0;
        if (k >= 1 && k <= 8) return b[k-1];
`ifdef TT_UART_PARITY_EN
        if (k == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    int  cyc        = 0;
    bit  prev_ready = 1'b1;
    int  acc_cnt    = 0;     // DUT acceptances seen (ready falling edges)
    int  last_acc   = -1;
    int  last_per   = 0;
    int  low_cnt    = 0;     // cycles with DUT ready low

    // Advance one clock: update model with the inputs present at the edge,
    // then compare the DUT shortly after the edge.
    task automatic step();
        logic [7:0] exp;
        @(posedge clk);
        if (!rst_n) begin
            m_busy = 1'b0;
        end else if (m_busy) begin
            m_t++;
            if (m_t == NB * DIV) m_busy = 1'b0;
        end else if (uio_in[0]) begin
            m_busy = 1'b1;
            m_t    = 0;
            m_byte = ui_in;
        end
        #1;
        cyc++;
        exp = m_busy ? {5'b0, 1'b1, 1'b0, frame_bit(m_t / DIV, m_byte)} : 8'h03;
        check("uo_out", {24'h0, uo_out}, {24'h0, exp});
        check("uio_out_oe", {16'h0, uio_out, uio_oe}, 32'h0);
        if (!uo_out[1]) low_cnt++;
        if (prev_ready && !uo_out[1]) begin
            acc_cnt++;
            if (last_acc >= 0) last_per = cyc - last_acc;
            last_acc = cyc;
        end
        prev_ready = uo_out[1];
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        // Reset for two cycles, then idle.
        rst_n  = 1'b0;
        uio_in = 8'h01;          // valid during reset must be ignored
        ui_in  = 8'hAA;
        run(2);
        rst_n  = 1'b1;
        uio_in = 8'h00;
        run(3);
        check("idle_ready", {31'h0, uo_out[1]}, 32'h1);

        // Single frame 0xA5, valid pulsed one cycle.
        ui_in  = 8'hA5;
        uio_in = 8'h01;
        low_cnt = 0;
        acc_cnt = 0;
        step();
        uio_in = 8'h00;
        ui_in  = 8'h00;
        run(NB * DIV + 4);
        check("a5_ready_low", low_cnt, NB * DIV);
        check("a5_frames", acc_cnt, 1);

        // Back-to-back: valid held, first frame 0x00 then 0xFF.
        ui_in    = 8'h00;
        uio_in   = 8'h01;
        acc_cnt  = 0;
        last_acc = -1;
        while (acc_cnt == 0 && cyc < 2000) step();
        check("b2b_first_accept", acc_cnt, 1);
        ui_in = 8'hFF;
        for (int i = 0; i < NB * DIV + 3 && acc_cnt < 2; i++) step();
        check("b2b_second_accept", acc_cnt, 2);
        check("b2b_period", last_per, NB * DIV + 1);
        uio_in = 8'h00;
        run(NB * DIV + 2);

        // 0x3C with ui_in change and a valid pulse during data bit 2.
        ui_in   = 8'h3C;
        uio_in  = 8'h01;
        acc_cnt = 0;
        step();
        uio_in = 8'h00;
        run(3 * DIV - 1);
        ui_in  = 8'hFF;
        uio_in = 8'h01;
        step();
        uio_in = 8'h00;
        run(NB * DIV + 4);
        check("3c_no_queue", acc_cnt, 1);

        // 0x55 aborted by reset during data bit 3, then 0x81.
        ui_in  = 8'h55;
        uio_in = 8'h01;
        step();
        uio_in = 8'h00;
        run(4 * DIV + 1);
        rst_n = 1'b0;
        step();
        check("abort_line", {24'h0, uo_out}, 32'h03);
        rst_n = 1'b1;
        run(2);
        ui_in   = 8'h81;
        uio_in  = 8'h01;
        acc_cnt = 0;
        step();
        uio_in = 8'h00;
        run(NB * DIV + 3);
        check("81_frames", acc_cnt, 1);

`ifdef TT_UART_PARITY_EN
        // Parity frames 0x07 (odd count of ones) and 0x03.
        ui_in  = 8'h07;
        uio_in = 8'h01;
        step();
        uio_in = 8'h00;
        run(9 * DIV);
        check("parity_07", {31'h0, uo_out[0]}, 32'h1);
        run(2 * DIV + 2);
        ui_in  = 8'h03;
        uio_in = 8'h01;
        low_cnt = 0;
        step();
        uio_in = 8'h00;
        run(9 * DIV);
        check("parity_03", {31'h0, uo_out[0]}, 32'h0);
        run(2 * DIV + 2);
        check("parity_ready_low", low_cnt, 44);
`endif

        // Randomized phase.
        for (int i = 0; i < 1500; i++) begin
            rst_n  = ($urandom_range(0, 299) != 0);
            uio_in = {$urandom_range(0, 127) & 7'h7F, ($urandom_range(0, 3) == 0)};
            ui_in  = 8'($urandom);
            step();
        end
        rst_n  = 1'b1;
        uio_in = 8'h00;
        run(NB * DIV + 2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
